// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI slave responder in front of one synchronous single-port SRAM macro.
//   Accepts INCR read and write bursts and turns every beat into one SRAM
//   access. A read costs two cycles per beat: a fetch cycle with CEB low, then
//   a data cycle that presents the word on R. A write beat is written in the
//   same cycle that WVALID is seen.
//
//   Optional feature macro: AXI_SRAM_RESP_CHECK_EN
//     When this macro is defined, a burst whose SIZE is not 4 bytes or whose
//     BURST is not INCR is flagged at the address handshake. A flagged burst
//     never touches the SRAM, and it returns SLVERR. A flagged read also
//     returns zero data.
//
// Ports
//   ACLK, rst          clock, synchronous active-high reset
//   AR*/R*             AXI read address and read data channels
//   AW*/W*/B*          AXI write address, write data and write response channels
//   CEB                SRAM chip enable, active low
//   WEB                SRAM byte write enables, active low (4'b1111 = read)
//   A, DI              SRAM word address and write data
//   DO                 SRAM read data, valid the cycle after a CEB-low read
module axi_sram_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              rst,
    input  logic [ID_W-1:0]   ARID,
    input  logic [31:0]       ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    input  logic [ID_W-1:0]   AWID,
    input  logic [31:0]       AWADDR,
    input  logic [3:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    output logic              CEB,
    output logic [3:0]        WEB,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] DI,
    input  logic [DATA_W-1:0] DO
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_RFETCH, S_RDATA, S_WRITE, S_WRESP} state_t;

    state_t              state_q;
    logic                last_wr_q;    // 1: the most recent burst served was a write
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [3:0]          len_q;
    logic [3:0]          cnt_q;
    logic                err_q;
    logic                rhold_q;      // 1 once the beat's DO word has been captured
    logic [DATA_W-1:0]   rdata_q;
    logic                rvalid_q, rlast_q, wready_q, bvalid_q;
    logic [ID_W-1:0]     rid_q, bid_q;
    logic [1:0]          rresp_q, bresp_q;
    logic                ar_hs, aw_hs, ar_bad, aw_bad;
    logic [DATA_W-1:0]   rd_word;
    logic                unused_bits;

    // Address bits outside the SRAM word range are not decoded.
    assign unused_bits = ^{ARADDR[31:ADDR_W+2], ARADDR[1:0], AWADDR[31:ADDR_W+2],
                           AWADDR[1:0], ARSIZE, ARBURST, AWSIZE, AWBURST};

`ifdef AXI_SRAM_RESP_CHECK_EN
    assign ar_bad = (ARSIZE != 3'b010) || (ARBURST != 2'b01);
    assign aw_bad = (AWSIZE != 3'b010) || (AWBURST != 2'b01);
`else
    assign ar_bad = 1'b0;
    assign aw_bad = 1'b0;
`endif

    // The READY lines are combinational so that, on a tie, the losing channel
    // sees READY low in the same cycle and its handshake cannot complete.
    assign ARREADY = (state_q == S_IDLE) && !rst && (!AWVALID || last_wr_q);
    assign AWREADY = (state_q == S_IDLE) && !rst && (!ARVALID || !last_wr_q);
    assign ar_hs   = ARVALID && ARREADY;
    assign aw_hs   = AWVALID && AWREADY;
    assign addr_d  = addr_q + 1'b1;  // wraps modulo 2^ADDR_W

    // DO is valid only in the first data cycle, so drive it straight through
    // in that cycle and replay the captured copy while RREADY stalls.
    assign rd_word = err_q ? '0 : DO;
    assign RDATA   = (state_q == S_RDATA && !rhold_q) ? rd_word : rdata_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RRESP   = rresp_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;

    // The SRAM pins follow the state. A write beat must reach the macro in the
    // same cycle as WVALID.
    always_comb begin
        CEB = 1'b1;
        WEB = 4'b1111;
        A   = '0;
        DI  = '0;
        if (!rst) begin
            case (state_q)
                S_RFETCH: if (!err_q) begin
                    CEB = 1'b0;
                    A   = addr_q;
                end
                S_WRITE: if (WVALID && !err_q) begin
                    CEB = 1'b0;
                    WEB = ~WSTRB;
                    A   = addr_q;
                    DI  = WDATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_wr_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rhold_q   <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ar_hs) begin
                        id_q      <= ARID;
                        addr_q    <= ARADDR[ADDR_W+1:2];
                        len_q     <= ARLEN;
                        cnt_q     <= '0;
                        err_q     <= ar_bad;
                        last_wr_q <= 1'b0;
                        state_q   <= S_RFETCH;
                    end else if (aw_hs) begin
                        id_q      <= AWID;
                        addr_q    <= AWADDR[ADDR_W+1:2];
                        len_q     <= AWLEN;
                        cnt_q     <= '0;
                        err_q     <= aw_bad;
                        last_wr_q <= 1'b1;
                        wready_q  <= 1'b1;
                        state_q   <= S_WRITE;
                    end
                end
                S_RFETCH: begin
                    rvalid_q <= 1'b1;
                    rlast_q  <= (cnt_q == len_q);
                    rid_q    <= id_q;
                    rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
                    rhold_q  <= 1'b0;
                    state_q  <= S_RDATA;
                end
                S_RDATA: begin
                    rhold_q <= 1'b1;
                    if (!rhold_q) rdata_q <= rd_word;
                    if (RREADY) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            addr_q  <= addr_d;
                            cnt_q   <= cnt_q + 4'd1;
                            state_q <= S_RFETCH;
                        end
                    end
                end
                S_WRITE: begin
                    if (WVALID) begin
                        addr_q <= addr_d;
                        if (cnt_q != 4'hF) cnt_q <= cnt_q + 4'd1;
                        // Only WLAST ends the burst; extra beats keep writing.
                        if (WLAST) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
                            state_q  <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (BREADY) begin
                        bvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural synchronous SRAM.
// Words that have never been written read back as 32'hA000_0000 | word_address.
module tb_axi_sram_slave;

    logic        ACLK = 1'b0;
    logic        rst;
    logic [7:0]  ARID, AWID, RID, BID;
    logic [31:0] ARADDR, AWADDR;
    logic [3:0]  ARLEN, AWLEN;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, AWVALID, AWREADY;
    logic [31:0] RDATA, WDATA, DI, DO;
    logic [3:0]  WSTRB, WEB;
    logic        WLAST, WVALID, WREADY, BVALID, BREADY, CEB;
    logic [13:0] A;

    int errors = 0;
    int checks = 0;
    int ceb_cnt = 0;

    always #5 ACLK = ~ACLK;

    axi_sram_slave #(.ID_W(8), .ADDR_W(14), .DATA_W(32)) dut (
        .ACLK(ACLK), .rst(rst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    // Synchronous single-port SRAM model.
    logic [31:0] mem [0:16383];
    bit          wr  [0:16383];

    always @(posedge ACLK) begin
        logic [31:0] cur;
        if (!CEB) begin
            ceb_cnt <= ceb_cnt + 1;
            cur = wr[A] ? mem[A] : (32'hA000_0000 | {18'd0, A});
            if (WEB == 4'b1111) begin
                DO <= cur;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (!WEB[b]) cur[b*8 +: 8] = DI[b*8 +: 8];
                mem[A] <= cur;
                wr[A]  <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic ar_issue(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
        ARVALID = 1'b1; ARADDR = addr; ARLEN = len; ARSIZE = 3'b010; ARBURST = 2'b01; ARID = id;
        #1;
        check("arready", ARREADY, 1);
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic aw_issue(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
        AWVALID = 1'b1; AWADDR = addr; AWLEN = len; AWSIZE = 3'b010; AWBURST = 2'b01; AWID = id;
        #1;
        check("awready", AWREADY, 1);
        tick();
        AWVALID = 1'b0;
    endtask

    // Entered with the DUT in the fetch cycle of a read beat.
    task automatic rbeat(input logic [13:0] ea, input logic [31:0] ed, input logic el,
                         input int stall, input logic [7:0] eid);
        int c0;
        #1;
        check("rfetch_ceb", CEB, 0);
        check("rfetch_web", WEB, 4'b1111);
        check("rfetch_a", A, ea);
        tick();
        RREADY = (stall == 0);
        c0 = ceb_cnt;
        for (int i = 0; i < stall; i++) begin
            #1;
            check("stall_rvalid", RVALID, 1);
            check("stall_rdata", RDATA, ed);
            check("stall_ceb", CEB, 1);
            tick();
        end
        RREADY = 1'b1;
        #1;
        check("rvalid", RVALID, 1);
        check("rdata", RDATA, ed);
        check("rlast", RLAST, el);
        check("rid", RID, eid);
        check("rresp", RRESP, 0);
        if (stall > 0) check("stall_no_ceb", ceb_cnt, c0);
        tick();
    endtask

    // Entered with the DUT in the write state.
    task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic last,
                         input logic [13:0] ea, input logic [3:0] eweb);
        WVALID = 1'b1; WDATA = d; WSTRB = s; WLAST = last;
        #1;
        check("wready", WREADY, 1);
        check("w_ceb", CEB, 0);
        check("w_web", WEB, eweb);
        check("w_a", A, ea);
        check("w_di", DI, d);
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    // Entered with the DUT in the response state; holds BREADY low one cycle.
    task automatic bresp_chk(input logic [7:0] eid);
        BREADY = 1'b0;
        check("bvalid", BVALID, 1);
        check("bresp", BRESP, 0);
        check("bid", BID, eid);
        tick();
        check("bvalid_hold", BVALID, 1);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("bvalid_clr", BVALID, 0);
    endtask

    initial begin
        rst = 1'b1;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010; ARBURST = 2'b01; ARVALID = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b0;
        RREADY = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_arready", ARREADY, 0);
        check("rst_awready", AWREADY, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rlast", RLAST, 0);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_rid", RID, 0);
        check("rst_bid", BID, 0);
        check("rst_rresp", RRESP, 0);
        check("rst_bresp", BRESP, 0);
        check("rst_ceb", CEB, 1);
        check("rst_web", WEB, 4'b1111);
        check("rst_a", A, 0);
        check("rst_di", DI, 0);
        rst = 1'b0;
        #1;
        check("idle_arready", ARREADY, 1);
        check("idle_awready", AWREADY, 1);

        // Single write then read back
        aw_issue(32'h0000_0010, 4'd0, 8'h01);
        wbeat(32'hDEAD_BEEF, 4'hF, 1'b1, 14'd4, 4'b0000);
        bresp_chk(8'h01);
        ar_issue(32'h0000_0010, 4'd0, 8'h02);
        rbeat(14'd4, 32'hDEAD_BEEF, 1'b1, 0, 8'h02);
        check("post_read_rvalid", RVALID, 0);

        // 4-beat read burst
        ar_issue(32'h0000_0100, 4'd3, 8'h04);
        rbeat(14'h040, 32'hA000_0040, 1'b0, 0, 8'h04);
        rbeat(14'h041, 32'hA000_0041, 1'b0, 0, 8'h04);
        rbeat(14'h042, 32'hA000_0042, 1'b0, 0, 8'h04);
        rbeat(14'h043, 32'hA000_0043, 1'b1, 0, 8'h04);
        check("burst_done_arready", ARREADY, 1);

        // RREADY backpressure on beat 2
        ar_issue(32'h0000_0200, 4'd3, 8'h05);
        rbeat(14'h080, 32'hA000_0080, 1'b0, 0, 8'h05);
        rbeat(14'h081, 32'hA000_0081, 1'b0, 5, 8'h05);
        rbeat(14'h082, 32'hA000_0082, 1'b0, 0, 8'h05);
        rbeat(14'h083, 32'hA000_0083, 1'b1, 0, 8'h05);

        // Partial strobe with an idle W cycle first
        aw_issue(32'h0000_0300, 4'd0, 8'h09);
        #1;
        check("wgap_ceb", CEB, 1);
        tick();
        wbeat(32'h1122_3344, 4'b0100, 1'b1, 14'h0C0, 4'b1011);
        bresp_chk(8'h09);
        ar_issue(32'h0000_0300, 4'd0, 8'h0A);
        rbeat(14'h0C0, 32'hA022_00C0, 1'b1, 0, 8'h0A);

        // Reset during beat 2 of an 8-beat read
        ar_issue(32'h0000_0400, 4'd7, 8'h03);
        rbeat(14'h100, 32'hA000_0100, 1'b0, 0, 8'h03);
        #1;
        check("mid_fetch_a", A, 14'h101);
        tick();
        rst = 1'b1;
        RREADY = 1'b0;
        tick();
        check("mid_rst_rvalid", RVALID, 0);
        check("mid_rst_ceb", CEB, 1);
        check("mid_rst_arready", ARREADY, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_arready_after", ARREADY, 1);
        check("mid_rst_ceb_after", CEB, 1);

        // Ties: read wins first after reset, then the write wins the next tie
        ARVALID = 1'b1; ARADDR = 32'h0000_0010; ARLEN = 4'd0; ARID = 8'h06;
        AWVALID = 1'b1; AWADDR = 32'h0000_0014; AWLEN = 4'd0; AWID = 8'h07;
        #1;
        check("tie1_arready", ARREADY, 1);
        check("tie1_awready", AWREADY, 0);
        tick();
        ARVALID = 1'b0;
        check("tie1_awready_busy", AWREADY, 0);
        rbeat(14'd4, 32'hDEAD_BEEF, 1'b1, 0, 8'h06);
        ARVALID = 1'b1; ARADDR = 32'h0000_0014; ARID = 8'h08;
        #1;
        check("tie2_awready", AWREADY, 1);
        check("tie2_arready", ARREADY, 0);
        tick();
        AWVALID = 1'b0;
        wbeat(32'h55AA_55AA, 4'hF, 1'b1, 14'd5, 4'b0000);
        bresp_chk(8'h07);
        #1;
        check("after_tie_arready", ARREADY, 1);
        tick();
        ARVALID = 1'b0;
        rbeat(14'd5, 32'h55AA_55AA, 1'b1, 0, 8'h08);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
